// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, reads one word per instruction over a
// req/ack handshake and holds it for decode until the control unit retires it.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        soc_clk,
    input  logic        reset,
    input  logic        pc_update_valid,
    input  logic        pc_update_sel,
    input  logic [31:0] pc_increment,
    input  logic [31:0] pc_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instruction,
    output logic        Fetch_ready,
    output logic [31:0] fetch_pc,
    output logic        misaligned_fetch,
    output logic        fetch_timeout
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   fpc_q, fpc_d;
    logic [XLEN-1:0]   next_pc;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rdy_q, rdy_d;
    logic              mis_q, mis_d;
    logic              tmo_q, tmo_d;

    // State register
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and fault registers
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            fpc_q   <= RESET_PC;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            mis_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            fpc_q   <= fpc_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            mis_q   <= mis_d;
            tmo_q   <= tmo_d;
        end
    end

    // Candidate next PC; 32-bit add, carry discarded
    assign next_pc = pc_update_sel ? pc_target : XLEN'(pc_q + pc_increment);

    // Next-state and register updates
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        fpc_d   = fpc_q;
        cnt_d   = cnt_q;
        rdy_d   = rdy_q;
        mis_d   = mis_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            ST_REQ: begin
                // An ack on the limit cycle still completes the fetch
                if (mem_ack) begin
                    instr_d = mem_rdata;
                    fpc_d   = pc_q;
                    rdy_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (pc_update_valid) begin
                    rdy_d = 1'b0;
                    if (next_pc[1:0] == 2'b00) begin
                        pc_d    = next_pc;
                        state_d = ST_REQ;
                    end else begin
                        mis_d   = 1'b1;
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // Request is withheld while reset is asserted
    assign mem_req          = (state_q == ST_REQ) && !reset;
    assign mem_addr         = pc_q;
    assign instruction      = instr_q;
    assign Fetch_ready      = rdy_q;
    assign fetch_pc         = fpc_q;
    assign misaligned_fetch = mis_q;
    assign fetch_timeout    = tmo_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed test-plan sequence plus random traffic, every
// cycle compared against a transaction-level model of the fetch stage.
module tb_ifu_fetch;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int unsigned TMO = 4;

    logic        soc_clk;
    logic        reset;
    logic        pc_update_valid;
    logic        pc_update_sel;
    logic [31:0] pc_increment;
    logic [31:0] pc_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instruction;
    logic        Fetch_ready;
    logic [31:0] fetch_pc;
    logic        misaligned_fetch;
    logic        fetch_timeout;

    ifu_fetch #(.RESET_PC(RPC), .TIMEOUT_CYCLES(TMO)) dut (
        .soc_clk         (soc_clk),
        .reset           (reset),
        .pc_update_valid (pc_update_valid),
        .pc_update_sel   (pc_update_sel),
        .pc_increment    (pc_increment),
        .pc_target       (pc_target),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .instruction     (instruction),
        .Fetch_ready     (Fetch_ready),
        .fetch_pc        (fetch_pc),
        .misaligned_fetch(misaligned_fetch),
        .fetch_timeout   (fetch_timeout)
    );

    initial soc_clk = 1'b0;
    always #5 soc_clk = ~soc_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: 0 = waiting for memory, 1 = word held for decode, 2 = dead until reset
    int          m_phase;
    int          m_wait;
    logic [31:0] m_pc, m_instr, m_fpc;
    bit          m_rdy, m_mis, m_tmo, m_rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit upd, input bit sel,
                              input logic [31:0] inc, input logic [31:0] tgt,
                              input bit ack, input logic [31:0] rdata);
        logic [31:0] nxt;
        m_rst = rst;
        if (rst) begin
            m_phase = 0; m_wait = 0; m_pc = RPC; m_instr = '0; m_fpc = RPC;
            m_rdy = 0; m_mis = 0; m_tmo = 0;
        end else if (m_phase == 0) begin
            if (ack) begin
                m_instr = rdata; m_fpc = m_pc; m_rdy = 1; m_wait = 0; m_phase = 1;
            end else begin
                m_wait++;
                if (m_wait >= int'(TMO)) begin
                    m_tmo = 1; m_phase = 2;
                end
            end
        end else if (m_phase == 1 && upd) begin
            nxt   = sel ? tgt : m_pc + inc;
            m_rdy = 0;
            if (nxt % 4 == 0) begin
                m_pc = nxt; m_phase = 0;
            end else begin
                m_mis = 1; m_phase = 2;
            end
        end
    endtask

    task automatic compare_all();
        chk("mem_req",          mem_req,          {31'b0, (m_phase == 0) && !m_rst});
        chk("mem_addr",         mem_addr,         m_pc);
        chk("instruction",      instruction,      m_instr);
        chk("Fetch_ready",      Fetch_ready,      {31'b0, m_rdy});
        chk("fetch_pc",         fetch_pc,         m_fpc);
        chk("misaligned_fetch", misaligned_fetch, {31'b0, m_mis});
        chk("fetch_timeout",    fetch_timeout,    {31'b0, m_tmo});
    endtask

    // One clock: drive inputs after the falling edge, predict, sample at next falling edge
    task automatic cyc(input bit rst, input bit upd, input bit sel,
                       input logic [31:0] inc, input logic [31:0] tgt,
                       input bit ack, input logic [31:0] rdata);
        reset = rst; pc_update_valid = upd; pc_update_sel = sel;
        pc_increment = inc; pc_target = tgt; mem_ack = ack; mem_rdata = rdata;
        model_step(rst, upd, sel, inc, tgt, ack, rdata);
        @(negedge soc_clk);
        compare_all();
    endtask

    task automatic idle();                     cyc(0, 0, 0, 0, 0, 0, 0);         endtask
    task automatic do_rst();                   cyc(1, 0, 0, 0, 0, 0, 0);         endtask
    task automatic do_ack(input logic [31:0] d); cyc(0, 0, 0, 0, 0, 1, d);       endtask
    task automatic upd_inc(input logic [31:0] i); cyc(0, 1, 0, i, 32'hDEAD_BEE0, 0, 0); endtask
    task automatic upd_tgt(input logic [31:0] t); cyc(0, 1, 1, 32'h4, t, 0, 0);  endtask

    initial begin
        logic [31:0] inc, tgt;
        bit rst, upd, sel, ack;
        int r;

        m_rst = 1;
        do_rst(); do_rst();
        chk("lit_rst_req",   mem_req, 32'h0);
        chk("lit_rst_addr",  mem_addr, RPC);
        chk("lit_rst_instr", instruction, 32'h0);

        // First fetch: ack on the second request cycle
        idle();
        chk("lit_req_after_rst", mem_req, 32'h1);
        chk("lit_addr_after_rst", mem_addr, 32'h0);
        do_ack(32'h0000_0537);
        chk("lit_rdy", Fetch_ready, 32'h1);
        chk("lit_instr", instruction, 32'h0000_0537);
        chk("lit_fpc", fetch_pc, 32'h0);

        // Sequential increments, negative offset
        upd_inc(32'h4);
        chk("lit_rdy_low", Fetch_ready, 32'h0);
        chk("lit_addr4", mem_addr, 32'h4);
        do_ack(32'h1111_1111);
        upd_inc(32'h4);
        do_ack(32'h2222_2222);
        chk("lit_fpc8", fetch_pc, 32'h8);
        upd_inc(32'hFFFF_FFF8);
        chk("lit_addr_back0", mem_addr, 32'h0);
        do_ack(32'h3333_3333);

        // Absolute target, then wrap past the top of the address space
        upd_tgt(32'h0000_0100);
        chk("lit_addr100", mem_addr, 32'h100);
        do_ack(32'h4444_4444);
        upd_tgt(32'hFFFF_FFFC);
        do_ack(32'h5555_5555);
        upd_inc(32'h4);
        chk("lit_wrap_addr", mem_addr, 32'h0);
        chk("lit_wrap_nofault", misaligned_fetch, 32'h0);
        do_ack(32'h6666_6666);

        // Misaligned target: dead until reset, inputs ignored
        upd_inc(32'h2);
        chk("lit_mis", misaligned_fetch, 32'h1);
        chk("lit_mis_req", mem_req, 32'h0);
        repeat (3) cyc(0, 1, 0, 32'h4, 0, 1, 32'hBAD0_BAD0);
        chk("lit_mis_instr", instruction, 32'h6666_6666);
        do_rst();
        chk("lit_mis_clear", misaligned_fetch, 32'h0);

        // Timeout after exactly TMO request cycles
        repeat (TMO) idle();
        chk("lit_tmo", fetch_timeout, 32'h1);
        chk("lit_tmo_req", mem_req, 32'h0);
        do_rst();
        repeat (TMO - 1) idle();
        do_ack(32'h7777_7777);
        chk("lit_tmo_edge_ok", fetch_timeout, 32'h0);
        chk("lit_tmo_edge_rdy", Fetch_ready, 32'h1);

        // Reset during a request with a coincident ack
        upd_inc(32'h4);
        cyc(1, 0, 0, 0, 0, 1, 32'hDEAD_DEAD);
        chk("lit_rst_ack_instr", instruction, 32'h0);
        idle();
        chk("lit_rst_ack_addr", mem_addr, RPC);
        chk("lit_rst_ack_req", mem_req, 32'h1);
        cyc(0, 1, 0, 32'h8, 0, 0, 0);
        chk("lit_upd_in_req", mem_addr, RPC);
        do_ack(32'h8888_8888);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 59) == 0) || (m_phase == 2 && $urandom_range(0, 7) == 0);
            upd = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 1) == 1;
            r   = $urandom_range(0, 19);
            if (r == 0)      inc = 32'h2;
            else if (r < 12) inc = 32'h4;
            else             inc = $urandom() & 32'hFFFF_FFFC;
            tgt = $urandom();
            if ($urandom_range(0, 19) != 0) tgt[1:0] = 2'b00;
            ack = ($urandom_range(0, 2) == 0);
            cyc(rst, upd, sel, inc, tgt, ack, $urandom());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
